// File: rtl/dm9000a_phy_init_seq.sv
// Power-up sequencer for the DM9000A internal PHY.
// Runs a fixed three-write list through the PHY-write engine, with a post-reset settle delay, per-write timeouts and retries.
module dm9000a_phy_init_seq #(
  parameter int unsigned RESET_WAIT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES    = 50000,
  parameter int unsigned MAX_RETRY         = 2,
  parameter logic [15:0] ANAR_VALUE        = 16'h01E1,
  parameter logic [15:0] BMCR_RUN_VALUE    = 16'h1200
) (
  input  logic        iDm9000aClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iPhyWrRunEnd,
  output logic        oPhyWrRunStart,
  output logic [15:0] oPhyWrReg,
  output logic [15:0] oPhyWrValue,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [1:0]  oStep
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(RESET_WAIT_CYCLES - 1);
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_END,
    RELEASE,
    SETTLE,
    DONE,
    ERROR
  } stateT;

  stateT       state, stateNext;
  logic [15:0] timer, timerNext;
  logic [1:0]  retryCnt, retryCntNext;
  logic [1:0]  stepIdx, stepIdxNext;
  logic        tmoFlag, tmoFlagNext;
  logic        runStart, runStartNext;
  logic [15:0] phyReg, phyRegNext;
  logic [15:0] phyValue, phyValueNext;
  logic        doneFlag, doneFlagNext;
  logic        errorFlag, errorFlagNext;

  function automatic logic [15:0] stepReg(input logic [1:0] s);
    case (s)
      2'd1:    stepReg = 16'h0004;
      default: stepReg = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] stepValue(input logic [1:0] s);
    case (s)
      2'd0:    stepValue = 16'h8000;
      2'd1:    stepValue = ANAR_VALUE;
      default: stepValue = BMCR_RUN_VALUE;
    endcase
  endfunction

  always_ff @(posedge iDm9000aClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      timer     <= '0;
      retryCnt  <= '0;
      stepIdx   <= '0;
      tmoFlag   <= 1'b0;
      runStart  <= 1'b0;
      phyReg    <= '0;
      phyValue  <= '0;
      doneFlag  <= 1'b0;
      errorFlag <= 1'b0;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      retryCnt  <= retryCntNext;
      stepIdx   <= stepIdxNext;
      tmoFlag   <= tmoFlagNext;
      runStart  <= runStartNext;
      phyReg    <= phyRegNext;
      phyValue  <= phyValueNext;
      doneFlag  <= doneFlagNext;
      errorFlag <= errorFlagNext;
    end
  end

  // Every state change clears the shared timer; a new step reloads address/value together with RunStart.
  always_comb begin
    stateNext     = state;
    timerNext     = timer;
    retryCntNext  = retryCnt;
    stepIdxNext   = stepIdx;
    tmoFlagNext   = tmoFlag;
    runStartNext  = runStart;
    phyRegNext    = phyReg;
    phyValueNext  = phyValue;
    doneFlagNext  = doneFlag;
    errorFlagNext = errorFlag;

    case (state)
      IDLE, DONE, ERROR: begin
        if (iStart) begin
          doneFlagNext  = 1'b0;
          errorFlagNext = 1'b0;
          stepIdxNext   = 2'd0;
          retryCntNext  = '0;
          runStartNext  = 1'b1;
          phyRegNext    = stepReg(2'd0);
          phyValueNext  = stepValue(2'd0);
          timerNext     = '0;
          stateNext     = WAIT_END;
        end
      end

      WAIT_END: begin
        if (iPhyWrRunEnd) begin
          tmoFlagNext  = 1'b0;
          runStartNext = 1'b0;
          timerNext    = '0;
          stateNext    = RELEASE;
        end else if (timer == TIMEOUT_LAST) begin
          tmoFlagNext  = 1'b1;
          runStartNext = 1'b0;
          timerNext    = '0;
          stateNext    = RELEASE;
        end else begin
          timerNext = timer + 16'd1;
        end
      end

      RELEASE: begin
        runStartNext = 1'b0;
        if (!iPhyWrRunEnd) begin
          timerNext = '0;
          if (tmoFlag) begin
            if (retryCnt < RETRY_LIMIT) begin
              retryCntNext = retryCnt + 2'd1;
              runStartNext = 1'b1;
              stateNext    = WAIT_END;
            end else begin
              errorFlagNext = 1'b1;
              stateNext     = ERROR;
            end
          end else begin
            case (stepIdx)
              2'd0: stateNext = SETTLE;
              2'd1: begin
                stepIdxNext  = 2'd2;
                retryCntNext = '0;
                runStartNext = 1'b1;
                phyRegNext   = stepReg(2'd2);
                phyValueNext = stepValue(2'd2);
                stateNext    = WAIT_END;
              end
              default: begin
                doneFlagNext = 1'b1;
                stateNext    = DONE;
              end
            endcase
          end
        end
      end

      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          stepIdxNext  = 2'd1;
          retryCntNext = '0;
          runStartNext = 1'b1;
          phyRegNext   = stepReg(2'd1);
          phyValueNext = stepValue(2'd1);
          timerNext    = '0;
          stateNext    = WAIT_END;
        end else begin
          timerNext = timer + 16'd1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign oPhyWrRunStart = runStart;
  assign oPhyWrReg      = phyReg;
  assign oPhyWrValue    = phyValue;
  assign oBusy          = (state != IDLE) && (state != DONE) && (state != ERROR);
  assign oDone          = doneFlag;
  assign oError         = errorFlag;
  assign oStep          = stepIdx;

endmodule
